// File: rtl/multi_sel_pkg.sv
// Shared types and constants for the multi_sel product stream receive side.
package multi_sel_pkg;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefOw = DefDw + 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StP1   = 2'd1,
    StP2   = 2'd2,
    StP3   = 2'd3
  } state_e;

  // Stream word order within a frame.
  localparam int unsigned PhaseD  = 0;
  localparam int unsigned PhaseX3 = 1;
  localparam int unsigned PhaseX7 = 2;
  localparam int unsigned PhaseX8 = 3;

  localparam int unsigned MulD  = 1;
  localparam int unsigned MulX3 = 3;
  localparam int unsigned MulX7 = 7;
  localparam int unsigned MulX8 = 8;

endpackage

// File: rtl/multi_sel_rx_if.sv
// Stream input and result bundle for multi_sel_rx; slave is the receiver's view.
interface multi_sel_rx_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned OW    = 11,
  parameter int unsigned CNT_W = 16
);
  logic             grant_i;
  logic [OW-1:0]    data_i;
  logic             res_valid;
  logic [DW-1:0]    res_d;
  logic [OW-1:0]    res_x3;
  logic [OW-1:0]    res_x7;
  logic [OW-1:0]    res_x8;
  logic             frame_abort;
  logic [CNT_W-1:0] frame_cnt;
  logic             chk_err;

  modport master (
    output grant_i, data_i,
    input  res_valid, res_d, res_x3, res_x7, res_x8, frame_abort, frame_cnt, chk_err
  );

  modport slave (
    input  grant_i, data_i,
    output res_valid, res_d, res_x3, res_x7, res_x8, frame_abort, frame_cnt, chk_err
  );
endinterface

// File: rtl/multi_sel_chk.sv
// Frame consistency check: flags a frame whose words are not d*1/3/7/8 of the captured d.
// Only instantiated when MULTI_SEL_RX_CHECK_EN is defined.
module multi_sel_chk
  import multi_sel_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned OW = DefOw
) (
  input  logic [DW-1:0]    d_i,
  input  logic [OW-DW-1:0] up_i,
  input  logic [OW-1:0]    x3_i,
  input  logic [OW-1:0]    x7_i,
  input  logic [OW-1:0]    x8_i,
  output logic             mismatch_o
);
  logic [OW-1:0] d_w;
  logic [OW-1:0] exp_x3, exp_x7, exp_x8;

  // OW = DW+3 leaves room for 8*d, so none of these products can overflow.
  always_comb begin
    d_w        = OW'(d_i) * OW'(MulD);
    exp_x3     = d_w * OW'(MulX3);
    exp_x7     = d_w * OW'(MulX7);
    exp_x8     = d_w * OW'(MulX8);
    mismatch_o = (|up_i) || (x3_i != exp_x3) || (x7_i != exp_x7) || (x8_i != exp_x8);
  end
endmodule

// File: rtl/multi_sel_rx.sv
// De-serialises 4-word multi_sel frames into parallel results and counts frames.
// Optional frame consistency check enabled by defining MULTI_SEL_RX_CHECK_EN.
module multi_sel_rx
  import multi_sel_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned OW    = DefOw,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  multi_sel_rx_if.slave  bus
);
  state_e           state_q, state_d;
  logic [DW-1:0]    d_q, d_d;
  logic [OW-1:0]    x3_q, x3_d;
  logic [OW-1:0]    x7_q, x7_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic             chk_q, chk_d;
  logic [DW-1:0]    res_d_q, res_d_d;
  logic [OW-1:0]    res_x3_q, res_x3_d;
  logic [OW-1:0]    res_x7_q, res_x7_d;
  logic [OW-1:0]    res_x8_q, res_x8_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;

`ifdef MULTI_SEL_RX_CHECK_EN
  logic [OW-DW-1:0] up_q, up_d;

  multi_sel_chk #(
    .DW (DW),
    .OW (OW)
  ) u_chk (
    .d_i        (d_q),
    .up_i       (up_q),
    .x3_i       (x3_q),
    .x7_i       (x7_q),
    .x8_i       (bus.data_i),
    .mismatch_o (mismatch)
  );
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    x3_d     = x3_q;
    x7_d     = x7_q;
    valid_d  = 1'b0;
    abort_d  = 1'b0;
    chk_d    = 1'b0;
    res_d_d  = res_d_q;
    res_x3_d = res_x3_q;
    res_x7_d = res_x7_q;
    res_x8_d = res_x8_q;
    cnt_d    = cnt_q;
`ifdef MULTI_SEL_RX_CHECK_EN
    up_d     = up_q;
`endif
    if (bus.grant_i) begin
      // A grant always starts a new frame; mid-frame it discards the current one.
      d_d     = bus.data_i[DW-1:0];
`ifdef MULTI_SEL_RX_CHECK_EN
      up_d    = bus.data_i[OW-1:DW];
`endif
      abort_d = (state_q != StIdle);
      state_d = StP1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StP1: begin
          x3_d    = bus.data_i;
          state_d = StP2;
        end
        StP2: begin
          x7_d    = bus.data_i;
          state_d = StP3;
        end
        StP3: begin
          res_d_d  = d_q;
          res_x3_d = x3_q;
          res_x7_d = x7_q;
          res_x8_d = bus.data_i;
          valid_d  = 1'b1;
          chk_d    = mismatch;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      d_q      <= '0;
      x3_q     <= '0;
      x7_q     <= '0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
      chk_q    <= 1'b0;
      res_d_q  <= '0;
      res_x3_q <= '0;
      res_x7_q <= '0;
      res_x8_q <= '0;
      cnt_q    <= '0;
`ifdef MULTI_SEL_RX_CHECK_EN
      up_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      x3_q     <= x3_d;
      x7_q     <= x7_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
      chk_q    <= chk_d;
      res_d_q  <= res_d_d;
      res_x3_q <= res_x3_d;
      res_x7_q <= res_x7_d;
      res_x8_q <= res_x8_d;
      cnt_q    <= cnt_d;
`ifdef MULTI_SEL_RX_CHECK_EN
      up_q     <= up_d;
`endif
    end
  end

  assign bus.res_valid   = valid_q;
  assign bus.frame_abort = abort_q;
  assign bus.chk_err     = chk_q;
  assign bus.res_d       = res_d_q;
  assign bus.res_x3      = res_x3_q;
  assign bus.res_x7      = res_x7_q;
  assign bus.res_x8      = res_x8_q;
  assign bus.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_multi_sel_rx.sv
// Scoreboard bench for multi_sel_rx; a second instance with a 2-bit counter checks wrapping.
module tb_multi_sel_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_sel_rx_if #(.DW(8), .OW(11), .CNT_W(16)) bus ();
  multi_sel_rx_if #(.DW(8), .OW(11), .CNT_W(2))  bus_w ();

  assign bus_w.grant_i = bus.grant_i;
  assign bus_w.data_i  = bus.data_i;

  multi_sel_rx #(.DW(8), .OW(11), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multi_sel_rx #(.DW(8), .OW(11), .CNT_W(2)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  typedef struct {
    int          due;
    logic [7:0]  d;
    logic [10:0] x3;
    logic [10:0] x7;
    logic [10:0] x8;
    logic [15:0] cnt;
    logic [1:0]  cnt_w;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nframes = 0;
  int   aborts_seen = 0;
  int   aborts_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_word(input logic g, input logic [10:0] w);
    @(posedge clk);
    #1;
    bus.grant_i = g;
    bus.data_i  = w;
  endtask

  task automatic send_frame(input logic [10:0] w0, input logic [10:0] x3,
                            input logic [10:0] x7, input logic [10:0] x8);
    exp_t e;
    int   dv;
    send_word(1'b1, w0);
    send_word(1'b0, x3);
    send_word(1'b0, x7);
    send_word(1'b0, x8);
    nframes++;
    dv      = int'(w0[7:0]);
    e.due   = cyc + 1;
    e.d     = w0[7:0];
    e.x3    = x3;
    e.x7    = x7;
    e.x8    = x8;
    e.cnt   = nframes[15:0];
    e.cnt_w = nframes[1:0];
`ifdef MULTI_SEL_RX_CHECK_EN
    e.chk = (w0[10:8] != 3'd0) || (x3 != 11'(3 * dv)) || (x7 != 11'(7 * dv))
            || (x8 != 11'(8 * dv));
`else
    e.chk = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_word(1'b0, 11'($urandom));
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_valid"}, bus.res_valid, 0);
    check_eq({pfx, "_abort"}, bus.frame_abort, 0);
    check_eq({pfx, "_chk"}, bus.chk_err, 0);
    check_eq({pfx, "_res_d"}, bus.res_d, 0);
    check_eq({pfx, "_x3"}, bus.res_x3, 0);
    check_eq({pfx, "_x7"}, bus.res_x7, 0);
    check_eq({pfx, "_x8"}, bus.res_x8, 0);
    check_eq({pfx, "_cnt"}, bus.frame_cnt, 0);
    check_eq({pfx, "_cnt_w"}, bus_w.frame_cnt, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.frame_abort) aborts_seen++;
      if (bus.res_valid) begin
        check_eq("valid_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e_cur = sb.pop_front();
          check_eq("latency", cyc, e_cur.due);
          check_eq("res_d", bus.res_d, e_cur.d);
          check_eq("res_x3", bus.res_x3, e_cur.x3);
          check_eq("res_x7", bus.res_x7, e_cur.x7);
          check_eq("res_x8", bus.res_x8, e_cur.x8);
          check_eq("frame_cnt", bus.frame_cnt, e_cur.cnt);
          check_eq("frame_cnt_wrap", bus_w.frame_cnt, e_cur.cnt_w);
          check_eq("chk_err", bus.chk_err, e_cur.chk);
        end
      end
    end
  end

  initial begin
    bus.grant_i = 1'b0;
    bus.data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    idle(2);

    send_frame(11'd5, 11'd15, 11'd35, 11'd40);
    idle(3);
    // Full-scale sample immediately followed by zero.
    send_frame(11'd255, 11'd765, 11'd1785, 11'd2040);
    send_frame(11'd0, 11'd0, 11'd0, 11'd0);
    idle(3);
    // Abort at phase 2: the second grant restarts with d=3.
    send_word(1'b1, 11'd9);
    send_word(1'b0, 11'd27);
    aborts_exp++;
    send_frame(11'd3, 11'd9, 11'd21, 11'd24);
    idle(3);
    check_eq("res_hold_d", bus.res_d, 8'd3);
    // Inconsistent frames: bad x7, then nonzero phase-0 upper bits.
    send_frame(11'd5, 11'd15, 11'd34, 11'd40);
    send_frame(11'h405, 11'd15, 11'd35, 11'd40);
    idle(3);

    // Reset in P2 drops the frame silently.
    send_word(1'b1, 11'd11);
    send_word(1'b0, 11'd33);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.grant_i = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    nframes = 0;
    idle(2);
    send_frame(11'd7, 11'd21, 11'd49, 11'd56);
    for (int i = 0; i < 4; i++) begin
      int dv;
      dv = int'($urandom_range(0, 255));
      send_frame(11'(dv), 11'(3 * dv), 11'(7 * dv), 11'(8 * dv));
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    idle(2);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("abort_count", aborts_seen, aborts_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multi_sel_rx.md
Name: multi_sel_rx

Overview:
- Receive-side collector for the multi_sel product stream.
- The stream carries one frame per input sample, four words on consecutive cycles: d*1, d*3, d*7, d*8. The frame starts on the cycle grant_i is high.
- Block de-serialises each frame into parallel result registers, presents them with a one-cycle valid pulse, and counts completed frames.
- Sits downstream of multi_sel; feeds consumers that need all four products of a sample at once.

Parameters:
- DW, 8: width of the original sample d.
- OW, 11: stream word width; must equal DW+3, since 8*(2^DW-1) must fit.
- CNT_W, 16: width of the completed-frame counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- grant_i  input  1  frame start; high on the cycle data_i carries d*1.
- data_i  input  OW  stream word.
- res_valid  output  1  one-cycle pulse; result registers hold a complete frame.
- res_d  output  DW  recovered sample, data_i[DW-1:0] of phase 0.
- res_x3  output  OW  phase-1 word.
- res_x7  output  OW  phase-2 word.
- res_x8  output  OW  phase-3 word.
- frame_abort  output  1  one-cycle pulse; an in-progress frame was discarded.
- frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W.
- chk_err  output  1  one-cycle pulse alongside res_valid; frame inconsistent. Tied 0 without the optional feature.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state IDLE;
  - all outputs 0: res_valid, frame_abort, chk_err, res_d, res_x3, res_x7, res_x8, frame_cnt;
  - all internal shadow registers 0.
- FSM states: IDLE, P1, P2, P3.
- IDLE:
  - grant_i=1: capture data_i[DW-1:0] into shadow d, go to P1.
  - grant_i=0: data_i ignored.
- P1:
  - grant_i=0: capture data_i into shadow x3, go to P2.
- P2:
  - grant_i=0: capture shadow x7, go to P3.
- P3:
  - grant_i=0: capture data_i as x8.
  - At that same clock edge: copy all shadows to res_* and set res_valid=1 for one cycle.
  - Increment frame_cnt; wraps to 0 at 2^CNT_W-1.
  - Return to IDLE.
- Latency: res_* and res_valid are visible in the cycle after the phase-3 word is on data_i, i.e. 4 cycles after the grant cycle.
- res_* hold their values until the next completed frame; an abort does not change them.
- Back-to-back frames: grant_i in the cycle immediately after P3 is accepted from IDLE. This gives a sustained throughput of one frame per 4 cycles.
- grant_i=1 while in P1, P2 or P3:
  - current frame discarded and frame_abort pulses 1 cycle;
  - new d captured from data_i;
  - next state P1;
  - frame_cnt, res_* and res_valid unchanged.
- Phase-0 bits data_i[OW-1:DW] are not stored. They are only checked when the optional feature is compiled in.
- Reset asserted mid-frame: frame dropped silently, with no abort pulse.

Optional Feature:
- Macro: MULTI_SEL_RX_CHECK_EN.
- Defined:
  - At frame completion, chk_err=1 with res_valid if any of these holds: phase-0 upper bits nonzero; x3 != 3*d; x7 != 7*d; x8 != d<<3.
  - Products are computed in OW bits; no overflow is possible for OW=DW+3.
  - res_* are still updated on an error.
- Undefined: no checker logic; chk_err constant 0.

Decomposition:
- Package multi_sel_pkg:
  - DW/OW defaults;
  - state enum {IDLE,P1,P2,P3};
  - phase constants;
  - product multipliers 1/3/7/8.
- Sub-module multi_sel_chk, instantiated only under MULTI_SEL_RX_CHECK_EN:
  - inputs: shadow d, upper bits, x3, x7, x8 in;
  - output: mismatch flag, combinational.

Test Plan:
- Frame d=5: words 5,15,35,40 with grant on word 0 -> after 4 cycles res_valid=1 for one cycle, res_d=5, x3=15, x7=35, x8=40, frame_cnt=1, chk_err=0.
- Max d=255: words 255,765,1785,2040, then d=0 back-to-back -> two res_valid pulses 4 cycles apart, second frame all 0, frame_cnt=2.
- Abort: d=9 frame, grant reasserted at phase 2 with d=3, then 9,21,24 -> frame_abort one pulse, single res_valid with res_d=3, x3=9, x7=21, x8=24, frame_cnt=1.
- Check (macro on): d=5 with x7=34 -> res_valid=1 and chk_err=1. Phase-0 word 0x405 -> chk_err=1. Macro off: chk_err stays 0.
- Reset: rst low at P2 for 1 cycle -> all outputs 0, no res_valid, no abort. Next clean frame d=7 -> res_d=7, frame_cnt=1.
- Wrap: CNT_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1.
